// File: rtl/pipe_alu_fwd_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipelined ALU datapath (pipe_alu_fwd):
//   - opcode class constants (bits [31:29] of the instruction word)
//   - function-code constants (bits [28:26])
//   - instruction field bit positions
//   - decoded-instruction struct and the decode helper
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

   // Opcode class: [31:30] must be 01, [29] selects immediate form
   localparam logic [2:0] OPC_R = 3'b010;
   localparam logic [2:0] OPC_I = 3'b011;

   // Function codes
   localparam logic [2:0] FN_NOP = 3'b000;
   localparam logic [2:0] FN_NOT = 3'b001;
   localparam logic [2:0] FN_ADD = 3'b010;
   localparam logic [2:0] FN_SUB = 3'b011;
   localparam logic [2:0] FN_OR  = 3'b100;
   localparam logic [2:0] FN_AND = 3'b101;
   localparam logic [2:0] FN_SLT = 3'b110;
   localparam logic [2:0] FN_XOR = 3'b111;

   // Instruction field positions
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 29;
   localparam int FN_MSB  = 28;
   localparam int FN_LSB  = 26;
   localparam int RD_MSB  = 25;
   localparam int RD_LSB  = 21;
   localparam int RS_MSB  = 20;
   localparam int RS_LSB  = 16;
   localparam int RT_MSB  = 15;
   localparam int RT_LSB  = 11;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   typedef struct packed {
      logic        valid;
      logic        is_imm;
      logic [2:0]  fn;
      logic [4:0]  rd;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [15:0] imm;
   } dec_instr_t;

   // Anything outside the two legal opcode classes, and function 000,
   // decodes as a NOP (valid cleared, so nothing is produced or written).
   function automatic dec_instr_t decode_instr(input logic [31:0] instr,
                                               input logic        issued);
      dec_instr_t d;
      logic [2:0] opc;
      opc      = instr[OPC_MSB:OPC_LSB];
      d.fn     = instr[FN_MSB:FN_LSB];
      d.rd     = instr[RD_MSB:RD_LSB];
      d.rs     = instr[RS_MSB:RS_LSB];
      d.rt     = instr[RT_MSB:RT_LSB];
      d.imm    = instr[IMM_MSB:IMM_LSB];
      d.is_imm = (opc == OPC_I);
      d.valid  = issued && ((opc == OPC_R) || (opc == OPC_I)) && (d.fn != FN_NOP);
      return d;
   endfunction

endpackage

// File: rtl/pipe_alu_fwd_alu.sv
// -----------------------------------------------------------------------------
// pipe_alu
// Purely combinational ALU for pipe_alu_fwd. Arithmetic wraps modulo
// 2^DATA_W; no flags are produced.
//   fn : function code (FN_* from pipe_pkg)
//   a  : operand A (rs)
//   b  : operand B (rt or zero-extended immediate); ignored by NOT
//   y  : result
// -----------------------------------------------------------------------------
module pipe_alu
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        fn,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      y = '0;
      case (fn)
         FN_NOT:  y = ~a;
         FN_ADD:  y = a + b;
         FN_SUB:  y = a - b;
         FN_OR:   y = a | b;
         FN_AND:  y = a & b;
         FN_SLT:  y[0] = ($signed(a) < $signed(b));
         FN_XOR:  y = a ^ b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/pipe_alu_fwd.sv
// -----------------------------------------------------------------------------
// pipe_alu_fwd
// Three-register pipelined ALU datapath (IF/ID -> ID/EX -> EX/WB, then a
// register-file write one edge later). One instruction per clock, no stalls.
// Optional macro PIPE_FWD_EN enables the EX/WB bypass at decode; without it
// decode reads the register file only (dependent instructions need two
// intervening issue slots).
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   InstrIn     : instruction word, sampled when WriteEnable=1
//   WriteEnable : 1 = issue InstrIn, 0 = insert bubble
//   ALUOut      : registered result of the instruction in WB
//   ALUValid    : ALUOut holds a new valid result this cycle
//   DbgAddr     : debug register-file read address
//   DbgData     : combinational register read, 0 when DbgAddr >= NREG
// -----------------------------------------------------------------------------
module pipe_alu_fwd
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       InstrIn,
   input  logic              WriteEnable,
   output logic [DATA_W-1:0] ALUOut,
   output logic              ALUValid,
   input  logic [4:0]        DbgAddr,
   output logic [DATA_W-1:0] DbgData
);

   localparam int RA_W = $clog2(NREG);

   function automatic logic addr_ok(input logic [4:0] addr);
      return int'(addr) < NREG;
   endfunction

   // Pipeline state
   logic [31:0]       ifid_instr_q;
   logic              ifid_valid_q;
   logic              idex_valid_q;
   logic              idex_we_q;
   logic [2:0]        idex_fn_q;
   logic [4:0]        idex_rd_q;
   logic [DATA_W-1:0] idex_a_q;
   logic [DATA_W-1:0] idex_b_q;
   logic [DATA_W-1:0] alu_out_q;
   logic              exwb_valid_q;
   logic              exwb_we_q;
   logic [4:0]        exwb_rd_q;
   logic [DATA_W-1:0] rf_q [NREG];

   dec_instr_t        dec;
   logic [DATA_W-1:0] rs_rf;
   logic [DATA_W-1:0] rt_rf;
   logic [DATA_W-1:0] op_a_d;
   logic [DATA_W-1:0] op_b_d;
   logic [DATA_W-1:0] alu_y;
   logic [DATA_W-1:0] alu_out_d;
   logic              idex_we_d;

   assign dec       = decode_instr(ifid_instr_q, ifid_valid_q);
   // Only in-range destinations write, and so only they may be bypassed:
   // an out-of-range source must still read as zero.
   assign idex_we_d = dec.valid && addr_ok(dec.rd);

   always_comb begin
      rs_rf = '0;
      rt_rf = '0;
      if (addr_ok(dec.rs)) rs_rf = rf_q[dec.rs[RA_W-1:0]];
      if (addr_ok(dec.rt)) rt_rf = rf_q[dec.rt[RA_W-1:0]];
   end

   // Operand selection. The EX result takes priority over WB because it is
   // the younger producer. The WB bypass also hides the same-edge register
   // write, so no write-through path is needed in the register file.
   always_comb begin
      op_a_d = rs_rf;
      op_b_d = dec.is_imm ? DATA_W'(dec.imm) : rt_rf;
`ifdef PIPE_FWD_EN
      if (idex_we_q && (idex_rd_q == dec.rs))
         op_a_d = alu_y;
      else if (exwb_we_q && (exwb_rd_q == dec.rs))
         op_a_d = alu_out_q;
      if (!dec.is_imm) begin
         if (idex_we_q && (idex_rd_q == dec.rt))
            op_b_d = alu_y;
         else if (exwb_we_q && (exwb_rd_q == dec.rt))
            op_b_d = alu_out_q;
      end
`endif
   end

   pipe_alu #(.DATA_W(DATA_W)) u_alu (
      .fn (idex_fn_q),
      .a  (idex_a_q),
      .b  (idex_b_q),
      .y  (alu_y)
   );

   // A bubble leaves the previous result visible on ALUOut.
   assign alu_out_d = idex_valid_q ? alu_y : alu_out_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ifid_instr_q <= '0;
         ifid_valid_q <= 1'b0;
         idex_valid_q <= 1'b0;
         idex_we_q    <= 1'b0;
         idex_fn_q    <= FN_NOP;
         idex_rd_q    <= '0;
         idex_a_q     <= '0;
         idex_b_q     <= '0;
         alu_out_q    <= '0;
         exwb_valid_q <= 1'b0;
         exwb_we_q    <= 1'b0;
         exwb_rd_q    <= '0;
      end else begin
         ifid_instr_q <= InstrIn;
         ifid_valid_q <= WriteEnable;
         idex_valid_q <= dec.valid;
         idex_we_q    <= idex_we_d;
         idex_fn_q    <= dec.fn;
         idex_rd_q    <= dec.rd;
         idex_a_q     <= op_a_d;
         idex_b_q     <= op_b_d;
         alu_out_q    <= alu_out_d;
         exwb_valid_q <= idex_valid_q;
         exwb_we_q    <= idex_we_q;
         exwb_rd_q    <= idex_rd_q;
      end
   end

   // Register file: cleared by reset, written from WB one edge after the
   // result appears on ALUOut.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (exwb_we_q) begin
         rf_q[exwb_rd_q[RA_W-1:0]] <= alu_out_q;
      end
   end

   assign ALUOut   = alu_out_q;
   assign ALUValid = exwb_valid_q;
   assign DbgData  = addr_ok(DbgAddr) ? rf_q[DbgAddr[RA_W-1:0]] : '0;

endmodule

// File: tb/tb_pipe_alu_fwd.sv
// -----------------------------------------------------------------------------
// tb_pipe_alu_fwd
// Directed testbench for pipe_alu_fwd: a default instance (DATA_W=32,
// NREG=32) and a narrow instance (DATA_W=16, NREG=8) sharing clock and reset.
// Expected results that depend on the bypass follow the PIPE_FWD_EN macro.
// -----------------------------------------------------------------------------
module tb_pipe_alu_fwd;

`ifdef PIPE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   localparam logic [2:0] F_NOT = 3'b001;
   localparam logic [2:0] F_ADD = 3'b010;
   localparam logic [2:0] F_SUB = 3'b011;
   localparam logic [2:0] F_OR  = 3'b100;
   localparam logic [2:0] F_AND = 3'b101;
   localparam logic [2:0] F_SLT = 3'b110;
   localparam logic [2:0] F_XOR = 3'b111;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        we;
   logic [31:0] alu_out;
   logic        alu_valid;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   logic [31:0] instr16;
   logic        we16;
   logic [15:0] alu_out16;
   logic        valid16;
   logic [4:0]  dbg_addr16;
   logic [15:0] dbg_data16;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   pipe_alu_fwd dut (
      .clk         (clk),
      .rst         (rst),
      .InstrIn     (instr),
      .WriteEnable (we),
      .ALUOut      (alu_out),
      .ALUValid    (alu_valid),
      .DbgAddr     (dbg_addr),
      .DbgData     (dbg_data)
   );

   pipe_alu_fwd #(.DATA_W(16), .NREG(8)) dut16 (
      .clk         (clk),
      .rst         (rst),
      .InstrIn     (instr16),
      .WriteEnable (we16),
      .ALUOut      (alu_out16),
      .ALUValid    (valid16),
      .DbgAddr     (dbg_addr16),
      .DbgData     (dbg_data16)
   );

   function automatic logic [31:0] enc_r(input logic [2:0] fn, input int rd, input int rs, input int rt);
      return {3'b010, fn, 5'(rd), 5'(rs), 5'(rt), 11'b0};
   endfunction

   function automatic logic [31:0] enc_i(input logic [2:0] fn, input int rd, input int rs, input logic [15:0] imm);
      return {3'b011, fn, 5'(rd), 5'(rs), imm};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      we = 1'b0;
      we16 = 1'b0;
      instr = '0;
      instr16 = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      chk_cnt++;
      if (alu_out !== 32'h0) $display("FAIL reset ALUOut: got %h expected 0", alu_out); else pass_cnt++;
      chk_cnt++;
      if (alu_valid !== 1'b0) $display("FAIL reset ALUValid: got %b expected 0", alu_valid); else pass_cnt++;
      chk_cnt++;
      if (alu_out16 !== 16'h0) $display("FAIL reset16 ALUOut: got %h expected 0", alu_out16); else pass_cnt++;
      chk_cnt++;
      if (valid16 !== 1'b0) $display("FAIL reset16 ALUValid: got %b expected 0", valid16); else pass_cnt++;
      for (int a = 0; a < 32; a++) begin
         dbg_addr = 5'(a);
         dbg_addr16 = 5'(a);
         #1;
         chk_cnt++;
         if (dbg_data !== 32'h0) $display("FAIL reset rf[%0d]: got %h expected 0", a, dbg_data); else pass_cnt++;
         chk_cnt++;
         if (dbg_data16 !== 16'h0) $display("FAIL reset16 rf[%0d]: got %h expected 0", a, dbg_data16); else pass_cnt++;
      end
      $display("txn reset: ALUOut=%h ALUValid=%b", alu_out, alu_valid);
   endtask

   task automatic test_legacy();
      logic [31:0] prog [13];
      logic [31:0] expv [13];
      prog[0]  = enc_i(F_ADD, 0, 0, 16'h0005);  expv[0]  = 32'h0000_0005;
      prog[1]  = enc_i(F_ADD, 1, 1, 16'h000A);  expv[1]  = 32'h0000_000A;
      prog[2]  = enc_i(F_ADD, 2, 2, 16'hFFF8);  expv[2]  = 32'h0000_FFF8;
      prog[3]  = enc_i(F_NOT, 3, 3, 16'h0000);  expv[3]  = 32'hFFFF_FFFF;
      prog[4]  = enc_i(F_OR,  4, 4, 16'hAAAA);  expv[4]  = 32'h0000_AAAA;
      prog[5]  = enc_i(F_AND, 5, 5, 16'hFFFF);  expv[5]  = 32'h0000_0000;
      prog[6]  = enc_i(F_SLT, 6, 6, 16'hFFF8);  expv[6]  = 32'h0000_0001;
      prog[7]  = enc_r(F_NOT, 7, 1, 0);         expv[7]  = 32'hFFFF_FFF5;
      prog[8]  = enc_r(F_ADD, 8, 1, 2);         expv[8]  = 32'h0001_0002;
      prog[9]  = enc_r(F_ADD, 9, 1, 3);         expv[9]  = 32'h0000_0009;
      prog[10] = enc_r(F_ADD, 10, 1, 4);        expv[10] = 32'h0000_AAB4;
      prog[11] = enc_r(F_ADD, 11, 1, 5);        expv[11] = 32'h0000_000A;
      prog[12] = enc_r(F_ADD, 12, 1, 6);        expv[12] = 32'h0000_000B;
      do_reset();
      for (int i = 0; i < 15; i++) begin
         if (i < 13) begin
            we = 1'b1;
            instr = prog[i];
         end else begin
            we = 1'b0;
            instr = '0;
         end
         step();
         if (i >= 2) begin
            $display("txn legacy[%0d]: ALUOut=%h ALUValid=%b", i - 2, alu_out, alu_valid);
            chk_cnt++;
            if (alu_valid !== 1'b1) $display("FAIL legacy[%0d] ALUValid: got %b expected 1", i - 2, alu_valid); else pass_cnt++;
            chk_cnt++;
            if (alu_out !== expv[i-2]) $display("FAIL legacy[%0d] ALUOut: got %h expected %h", i - 2, alu_out, expv[i-2]); else pass_cnt++;
         end
      end
      step();
      step();
      for (int r = 0; r < 13; r++) begin
         dbg_addr = 5'(r);
         #1;
         chk_cnt++;
         if (dbg_data !== expv[r]) $display("FAIL legacy rf[%0d]: got %h expected %h", r, dbg_data, expv[r]); else pass_cnt++;
      end
   endtask

   task automatic test_ex_fwd();
      logic [31:0] exp_add;
      exp_add = FWD ? 32'h0000_000A : 32'h0000_0000;
      do_reset();
      we = 1'b1;
      instr = enc_i(F_ADD, 1, 1, 16'h0005);
      step();
      instr = enc_r(F_ADD, 2, 1, 1);
      step();
      we = 1'b0;
      instr = '0;
      step();
      chk_cnt++;
      if (alu_out !== 32'h5) $display("FAIL ex_fwd ADDI ALUOut: got %h expected 5", alu_out); else pass_cnt++;
      step();
      $display("txn ex_fwd ADD: ALUOut=%h ALUValid=%b", alu_out, alu_valid);
      chk_cnt++;
      if (alu_valid !== 1'b1) $display("FAIL ex_fwd ADD ALUValid: got %b expected 1", alu_valid); else pass_cnt++;
      chk_cnt++;
      if (alu_out !== exp_add) $display("FAIL ex_fwd ADD ALUOut: got %h expected %h", alu_out, exp_add); else pass_cnt++;
      step();
      dbg_addr = 5'd2;
      #1;
      chk_cnt++;
      if (dbg_data !== exp_add) $display("FAIL ex_fwd rf[2]: got %h expected %h", dbg_data, exp_add); else pass_cnt++;
   endtask

   task automatic test_wb_fwd();
      logic [31:0] exp_sub;
      exp_sub = FWD ? 32'h0000_0007 : 32'h0000_0000;
      do_reset();
      we = 1'b1;
      instr = enc_i(F_ADD, 1, 1, 16'h0007);
      step();
      we = 1'b0;
      instr = '0;
      step();
      we = 1'b1;
      instr = enc_r(F_SUB, 3, 1, 0);
      step();
      we = 1'b0;
      instr = '0;
      chk_cnt++;
      if (alu_out !== 32'h7 || alu_valid !== 1'b1) $display("FAIL wb_fwd ADDI: got %h/%b expected 7/1", alu_out, alu_valid); else pass_cnt++;
      step();
      $display("txn wb_fwd bubble: ALUOut=%h ALUValid=%b", alu_out, alu_valid);
      chk_cnt++;
      if (alu_valid !== 1'b0) $display("FAIL wb_fwd bubble ALUValid: got %b expected 0", alu_valid); else pass_cnt++;
      chk_cnt++;
      if (alu_out !== 32'h7) $display("FAIL wb_fwd bubble ALUOut: got %h expected 7", alu_out); else pass_cnt++;
      step();
      $display("txn wb_fwd SUB: ALUOut=%h ALUValid=%b", alu_out, alu_valid);
      chk_cnt++;
      if (alu_valid !== 1'b1) $display("FAIL wb_fwd SUB ALUValid: got %b expected 1", alu_valid); else pass_cnt++;
      chk_cnt++;
      if (alu_out !== exp_sub) $display("FAIL wb_fwd SUB ALUOut: got %h expected %h", alu_out, exp_sub); else pass_cnt++;
   endtask

   task automatic test_new_ops();
      logic [31:0] prog [5];
      logic [31:0] expv [5];
      prog[0] = enc_i(F_ADD, 1, 0, 16'hFFFF);  expv[0] = 32'h0000_FFFF;
      prog[1] = enc_i(F_NOT, 2, 2, 16'h0000);  expv[1] = 32'hFFFF_FFFF;
      prog[2] = enc_i(F_SUB, 5, 0, 16'h0001);  expv[2] = 32'hFFFF_FFFF;
      prog[3] = enc_i(F_XOR, 4, 1, 16'h00FF);  expv[3] = 32'h0000_FF00;
      prog[4] = enc_r(F_SLT, 3, 2, 1);         expv[4] = 32'h0000_0001;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         if (i < 5) begin
            we = 1'b1;
            instr = prog[i];
         end else begin
            we = 1'b0;
            instr = '0;
         end
         step();
         if (i >= 2) begin
            $display("txn new_ops[%0d]: ALUOut=%h ALUValid=%b", i - 2, alu_out, alu_valid);
            chk_cnt++;
            if (alu_out !== expv[i-2] || alu_valid !== 1'b1)
               $display("FAIL new_ops[%0d]: got %h/%b expected %h/1", i - 2, alu_out, alu_valid, expv[i-2]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      we = 1'b1;
      instr = enc_i(F_ADD, 1, 0, 16'h0001);
      step();
      instr = enc_i(F_ADD, 2, 0, 16'h0002);
      step();
      rst = 1'b1;
      instr = enc_i(F_ADD, 3, 0, 16'h0003);
      step();
      rst = 1'b0;
      we = 1'b0;
      instr = '0;
      chk_cnt++;
      if (alu_out !== 32'h0 || alu_valid !== 1'b0) $display("FAIL midreset outputs: got %h/%b expected 0/0", alu_out, alu_valid); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_cnt++;
         if (alu_out !== 32'h0 || alu_valid !== 1'b0)
            $display("FAIL midreset drain[%0d]: got %h/%b expected 0/0", i, alu_out, alu_valid);
         else pass_cnt++;
      end
      for (int a = 0; a < 32; a++) begin
         dbg_addr = 5'(a);
         #1;
         chk_cnt++;
         if (dbg_data !== 32'h0) $display("FAIL midreset rf[%0d]: got %h expected 0", a, dbg_data); else pass_cnt++;
      end
      $display("txn midreset: ALUOut=%h ALUValid=%b", alu_out, alu_valid);
   endtask

   task automatic test_param();
      logic [31:0] prog [11];
      logic [15:0] expv [11];
      logic        vld  [11];
      logic [15:0] hold;
      for (int i = 0; i < 11; i++) begin
         prog[i] = '0;
         expv[i] = '0;
         vld[i]  = 1'b0;
      end
      prog[0]  = enc_i(F_ADD, 2, 0, 16'h0003);   expv[0]  = 16'h0003; vld[0]  = 1'b1;
      prog[3]  = enc_i(F_ADD, 9, 0, 16'h0055);   expv[3]  = 16'h0055; vld[3]  = 1'b1;
      prog[4]  = enc_r(F_ADD, 1, 10, 0);         expv[4]  = 16'h0000; vld[4]  = 1'b1;
      prog[7]  = enc_i(F_ADD, 1, 1, 16'hFFFF);   expv[7]  = 16'hFFFF; vld[7]  = 1'b1;
      prog[10] = enc_i(F_ADD, 1, 1, 16'h0001);   expv[10] = 16'h0000; vld[10] = 1'b1;
      hold = 16'h0;
      do_reset();
      for (int i = 0; i < 13; i++) begin
         if (i < 11) begin
            we16 = vld[i];
            instr16 = prog[i];
         end else begin
            we16 = 1'b0;
            instr16 = '0;
         end
         step();
         if (i >= 2) begin
            $display("txn param[%0d]: ALUOut=%h ALUValid=%b", i - 2, alu_out16, valid16);
            if (vld[i-2]) hold = expv[i-2];
            chk_cnt++;
            if (valid16 !== vld[i-2]) $display("FAIL param[%0d] ALUValid: got %b expected %b", i - 2, valid16, vld[i-2]); else pass_cnt++;
            chk_cnt++;
            if (alu_out16 !== hold) $display("FAIL param[%0d] ALUOut: got %h expected %h", i - 2, alu_out16, hold); else pass_cnt++;
         end
         if (i == 6) begin
            dbg_addr16 = 5'd1;
            #1;
            chk_cnt++;
            if (dbg_data16 !== 16'h0) $display("FAIL param rd9 aliased into rf[1]: got %h expected 0", dbg_data16); else pass_cnt++;
            dbg_addr16 = 5'd9;
            #1;
            chk_cnt++;
            if (dbg_data16 !== 16'h0) $display("FAIL param rf[9] out of range: got %h expected 0", dbg_data16); else pass_cnt++;
         end
      end
      step();
      dbg_addr16 = 5'd1;
      #1;
      chk_cnt++;
      if (dbg_data16 !== 16'h0) $display("FAIL param rf[1] wrap: got %h expected 0", dbg_data16); else pass_cnt++;
      dbg_addr16 = 5'd2;
      #1;
      chk_cnt++;
      if (dbg_data16 !== 16'h3) $display("FAIL param rf[2]: got %h expected 3", dbg_data16); else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1;
      we = 1'b0;
      instr = '0;
      we16 = 1'b0;
      instr16 = '0;
      dbg_addr = '0;
      dbg_addr16 = '0;
      test_reset();
      test_legacy();
      test_ex_fwd();
      test_wb_fwd();
      test_new_ops();
      test_reset_midflight();
      test_param();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
